// File: rtl/restoring_divider8.sv
// Multi-cycle unsigned restoring divider: one shift-subtract-restore iteration
// per clock, results held until the next accepted start.
module restoring_divider8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;
  logic             accept;

  // One restoring iteration; returns {next partial remainder, next quotient}.
  function automatic logic [2*WIDTH:0] div_step(
    input logic [WIDTH:0]   r_in,
    input logic [WIDTH-1:0] q_in,
    input logic [WIDTH-1:0] d_in
  );
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_sh;
    shifted = {r_in[WIDTH-1:0], q_in[WIDTH-1]};
    q_sh    = {q_in[WIDTH-2:0], 1'b0};
    trial   = shifted - {1'b0, d_in};
    if (!trial[WIDTH])
      return {trial, q_sh[WIDTH-1:1], 1'b1};
    else
      return {shifted, q_sh};
  endfunction

  assign accept = start && ((state == IDLE) || (state == DONE));

  always_comb begin
    {r_next, q_next} = div_step(r, q, d);
  end

  // Control and result registers; reset aborts any in-flight division.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (accept) begin
            cnt         <= '0;
            div_by_zero <= (divisor == '0);
            if (divisor == '0) begin
              state     <= DONE;
              done      <= 1'b1;
              quotient  <= '1;
              remainder <= dividend;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_next;
            remainder <= r_next[WIDTH-1:0];
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Datapath registers carry no reset; they are loaded on every accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      r <= '0;
      q <= dividend;
      d <= divisor;
    end else if (state == RUN) begin
      r <= r_next;
      q <= q_next;
    end
  end

endmodule

// File: tb/tb_restoring_divider8.sv
// Directed scoreboard bench for restoring_divider8.
module tb_restoring_divider8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  restoring_divider8 #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request and record the reference result.
  task automatic drive(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    if (b == 8'h00) begin
      e.q = 8'hFF; e.r = a; e.dz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0;
    end
    sb.push_back(e);
  endtask

  task automatic compare_result(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, (sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_quotient"}, quotient, e.q);
      check({tag, "_remainder"}, remainder, e.r);
      check({tag, "_div_by_zero"}, div_by_zero, e.dz);
    end
  endtask

  // Single operation from IDLE; inj>=0 pulses a stray start that many cycles into the wait.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b, input int inj);
    int lat;
    int busy_n;
    drive(a, b);
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
    lat = 0;
    busy_n = 0;
    while (!done && lat < 20) begin
      if (busy) busy_n++;
      if (lat == inj) begin
        start = 1'b1; dividend = 8'h10; divisor = 8'h02;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    check({tag, "_latency"}, lat, (b == 8'h00) ? 0 : 8);
    check({tag, "_busy_cycles"}, busy_n, (b == 8'h00) ? 0 : 8);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    compare_result(tag);
    @(posedge clk); #1;
    check({tag, "_done_pulse_ends"}, done, 1'b0);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [7:0] a_list [3];
    logic [7:0] b_list [3];
    a_list = '{8'h64, 8'hC8, 8'h37};
    b_list = '{8'h07, 8'h0D, 8'h05};

    rst = 1'b0; start = 1'b0; dividend = 8'h00; divisor = 8'h00;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_quotient", quotient, 8'h00);
    check("rst_remainder", remainder, 8'h00);
    check("rst_dz", div_by_zero, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op("op_9A_0A", 8'h9A, 8'h0A, -1);
    do_op("op_CD_1E", 8'hCD, 8'h1E, -1);
    do_op("op_FF_01", 8'hFF, 8'h01, -1);
    do_op("op_05_09", 8'h05, 8'h09, -1);
    do_op("op_12_00", 8'h12, 8'h00, -1);
    do_op("op_64_07", 8'h64, 8'h07, -1);
    do_op("op_00_FF", 8'h00, 8'hFF, -1);

    // Stray start three cycles into RUN must be ignored.
    do_op("ign_9A_0A", 8'h9A, 8'h0A, 3);
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("ign_extra_done", pulses, 0);
    check("ign_sb_drained", sb.size(), 0);

    // Back-to-back with start held and operands changed at each done.
    drive(a_list[0], b_list[0]);
    for (int i = 0; i < 3; i++) begin
      lat = 0;
      do begin
        @(posedge clk); #1;
        lat++;
        if (lat == 1) begin
          dividend = 8'($urandom);
          divisor  = 8'($urandom);
        end
      end while (!done && lat < 20);
      check($sformatf("b2b%0d_interval", i), lat, 9);
      compare_result($sformatf("b2b%0d", i));
      if (i < 2) drive(a_list[i+1], b_list[i+1]);
      else start = 1'b0;
    end
    @(posedge clk); #1;
    check("b2b_done_ends", done, 1'b0);

    // Asynchronous abort mid-RUN.
    drive(8'hCD, 8'h1E);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_quotient", quotient, 8'h00);
    check("abort_remainder", remainder, 8'h00);
    check("abort_dz", div_by_zero, 1'b0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    do_op("post_abort_CD_1E", 8'hCD, 8'h1E, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
